// File: rtl/gcd_seq_engine.sv
// gcd_seq_engine: sequential binary (Stein) GCD engine with valid/ready
// operand and result handshakes.
//
// Handshakes: an operand pair transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is high only in IDLE and out_valid only
// in DONE, so at most one pair is ever in flight. A consumed result returns
// the engine to IDLE; a new pair can be taken on the following edge.
//
// Optional feature: define GCD_CYCLE_CNT_EN to add the CYCLES output, an
// 8-bit saturating count of CALC cycles spent on the current result.
module gcd_seq_engine #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] GCD,
`ifdef GCD_CYCLE_CNT_EN
  output logic [7:0]   CYCLES,
`endif
  output logic [1:0]   dbg_state_o
);

  // Wide enough to count W common factors of two; the shift stays <= W-1.
  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  gcd_q, gcd_d;
  logic [W-1:0]  a_minus_b;
  logic [W-1:0]  b_minus_a;

  // Differences are only selected when the minuend is larger, so no wrap.
  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
    end
  end

  // Next-state logic: capture in IDLE, one Stein step per CALC edge, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    gcd_d   = gcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if ((a_q == b_q) || (a_q == '0) || (b_q == '0)) begin
          gcd_d   = (a_q | b_q) << k_q;
          state_d = DONE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 1'b1;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = a_minus_b >> 1;
        end else begin
          b_d = b_minus_a >> 1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef GCD_CYCLE_CNT_EN
  logic [7:0] cyc_q, cyc_d;

  // CALC-cycle counter: cleared on acceptance, saturates at 255, frozen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  // Counter next value.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == IDLE) && in_valid) begin
      cyc_d = '0;
    end else if ((state_q == CALC) && (cyc_q != 8'hFF)) begin
      cyc_d = cyc_q + 8'd1;
    end
  end

  assign CYCLES = cyc_q;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign GCD         = gcd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcd_seq_engine.sv
// Testbench for gcd_seq_engine: a W=7 instance and a W=16 instance share the
// clock and reset. Results are compared against a Euclid reference model.
// Build with GCD_CYCLE_CNT_EN defined to also check the CYCLES port.
module tb_gcd_seq_engine;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- W=7 instance ----------------
  logic       in_valid7 = 1'b0;
  logic       in_ready7;
  logic [6:0] A7 = '0;
  logic [6:0] B7 = '0;
  logic       out_valid7;
  logic       out_ready7 = 1'b0;
  logic [6:0] GCD7;
  logic [1:0] dbg7;
`ifdef GCD_CYCLE_CNT_EN
  logic [7:0] CYCLES7;
`endif

  gcd_seq_engine #(.W(7)) dut7 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid7),
    .in_ready   (in_ready7),
    .A          (A7),
    .B          (B7),
    .out_valid  (out_valid7),
    .out_ready  (out_ready7),
    .GCD        (GCD7),
`ifdef GCD_CYCLE_CNT_EN
    .CYCLES     (CYCLES7),
`endif
    .dbg_state_o(dbg7)
  );

  // ---------------- W=16 instance ----------------
  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] A16 = '0;
  logic [15:0] B16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] GCD16;
  logic [1:0]  dbg16;
`ifdef GCD_CYCLE_CNT_EN
  logic [7:0]  CYCLES16;
`endif

  gcd_seq_engine #(.W(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid16),
    .in_ready   (in_ready16),
    .A          (A16),
    .B          (B16),
    .out_valid  (out_valid16),
    .out_ready  (out_ready16),
    .GCD        (GCD16),
`ifdef GCD_CYCLE_CNT_EN
    .CYCLES     (CYCLES16),
`endif
    .dbg_state_o(dbg16)
  );

  // ---------------- reference model ----------------
  function automatic int ref_gcd(input int x, input int y);
    int a;
    int b;
    int t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // ---------------- driver (W=7) ----------------
  // Runs one transaction with out_ready held high. Returns the result seen at
  // the first out_valid, the measured latency in cycles, the CYCLES value (or
  // the measured latency when the port is absent), a timeout flag, and the
  // out_valid/in_ready levels one cycle after the result was consumed.
  task automatic do7(input logic [6:0] a, input logic [6:0] b,
                     output logic [6:0] g, output int cyc, output logic [7:0] cport,
                     output bit to, output logic pv, output logic pr);
    int n;
    to = 1'b0;
    n = 0;
    out_ready7 = 1'b1;
    while (!in_ready7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready7) to = 1'b1;
    A7 = a;
    B7 = b;
    in_valid7 = 1'b1;
    @(negedge clk);
    in_valid7 = 1'b0;
    A7 = 7'($urandom);
    B7 = 7'($urandom);
    n = 0;
    while (!out_valid7 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid7) to = 1'b1;
    cyc = n;
    g = GCD7;
`ifdef GCD_CYCLE_CNT_EN
    cport = CYCLES7;
`else
    cport = 8'(n);
`endif
    @(negedge clk);
    pv = out_valid7;
    pr = in_ready7;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    checks++;
    if (in_ready7 !== 1'b1 || out_valid7 !== 1'b0 || GCD7 !== 7'd0) begin
      errors++;
      $display("FAIL reset_w7: in_ready=%b out_valid=%b gcd=%0d want 1 0 0", in_ready7, out_valid7, GCD7);
    end
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || GCD16 !== 16'd0) begin
      errors++;
      $display("FAIL reset_w16: in_ready=%b out_valid=%b gcd=%0d want 1 0 0", in_ready16, out_valid16, GCD16);
    end
`ifdef GCD_CYCLE_CNT_EN
    checks++;
    if (CYCLES7 !== 8'd0 || CYCLES16 !== 8'd0) begin
      errors++;
      $display("FAIL reset_cycles: got %0d/%0d want 0", CYCLES7, CYCLES16);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [6:0] g;
    int cyc;
    logic [7:0] cp;
    bit to;
    logic pv;
    logic pr;
    do7(7'd42, 7'd10, g, cyc, cp, to, pv, pr);
    checks++;
    if (to || g !== 7'd2) begin
      errors++;
      $display("FAIL basic_gcd: got %0d (timeout=%0d) want 2", g, to);
    end
    checks++;
    if (pv !== 1'b0 || pr !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b after consume want 0 1", pv, pr);
    end
    checks++;
    if (cyc < 1 || cyc > 15 || int'(cp) != cyc) begin
      errors++;
      $display("FAIL basic_cycles: latency=%0d cycles_port=%0d want equal in 1..15", cyc, cp);
    end
  endtask

  task automatic test_boundary;
    logic [6:0] av[4] = '{7'd0, 7'd0, 7'd25, 7'd33};
    logic [6:0] bv[4] = '{7'd0, 7'd33, 7'd25, 7'd0};
    logic [6:0] ev[4] = '{7'd0, 7'd33, 7'd25, 7'd33};
    logic [6:0] g;
    int cyc;
    logic [7:0] cp;
    bit to;
    logic pv;
    logic pr;
    for (int i = 0; i < 4; i++) begin
      do7(av[i], bv[i], g, cyc, cp, to, pv, pr);
      checks++;
      if (to || g !== ev[i]) begin
        errors++;
        $display("FAIL boundary_gcd(%0d,%0d): got %0d want %0d", av[i], bv[i], g, ev[i]);
      end
      checks++;
      if (cyc != 1 || cp !== 8'd1) begin
        errors++;
        $display("FAIL boundary_cycles(%0d,%0d): latency=%0d cycles_port=%0d want 1", av[i], bv[i], cyc, cp);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready7 = 1'b0;
    A7 = 7'd80;
    B7 = 7'd32;
    in_valid7 = 1'b1;
    @(negedge clk);
    in_valid7 = 1'b0;
    n = 0;
    while (!out_valid7 && n < 64) begin
      checks++;
      if (in_ready7 !== 1'b0) begin
        errors++;
        $display("FAIL bp_calc_ready: in_ready=%b want 0", in_ready7);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid7 !== 1'b1 || GCD7 !== 7'd16) begin
      errors++;
      $display("FAIL bp_gcd: out_valid=%b gcd=%0d want 1 16", out_valid7, GCD7);
    end
    for (int i = 0; i < 5; i++) begin
      A7 = 7'($urandom);
      B7 = 7'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid7 !== 1'b1 || GCD7 !== 7'd16 || in_ready7 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b gcd=%0d in_ready=%b want 1 16 0", i, out_valid7, GCD7, in_ready7);
      end
    end
    out_ready7 = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b0 || in_ready7 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid7, in_ready7);
    end
    out_ready7 = 1'b0;
  endtask

  task automatic test_wide_ignore;
    int n;
    out_ready16 = 1'b0;
    A16 = 16'd65535;
    B16 = 16'd1;
    in_valid16 = 1'b1;
    @(negedge clk);
    // Stray pair while in CALC must be ignored.
    A16 = 16'd100;
    B16 = 16'd10;
    in_valid16 = 1'b1;
    @(negedge clk);
    n = 1;
    in_valid16 = 1'b0;
    while (!out_valid16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid16 !== 1'b1 || GCD16 !== 16'd1) begin
      errors++;
      $display("FAIL wide_gcd: out_valid=%b gcd=%0d want 1 1", out_valid16, GCD16);
    end
    checks++;
    if (n < 1 || n > 33) begin
      errors++;
      $display("FAIL wide_cycles: latency=%0d want 1..33", n);
    end
`ifdef GCD_CYCLE_CNT_EN
    checks++;
    if (int'(CYCLES16) != n) begin
      errors++;
      $display("FAIL wide_cycles_port: got %0d want %0d", CYCLES16, n);
    end
`endif
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      errors++;
      $display("FAIL wide_release: out_valid=%b in_ready=%b want 0 1", out_valid16, in_ready16);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      errors++;
      $display("FAIL wide_no_stray: out_valid=%b in_ready=%b want 0 1", out_valid16, in_ready16);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] g;
    int cyc;
    logic [7:0] cp;
    bit to;
    logic pv;
    logic pr;
    out_ready7 = 1'b1;
    A7 = 7'd54;
    B7 = 7'd66;
    in_valid7 = 1'b1;
    @(negedge clk);
    in_valid7 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b0 || in_ready7 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_calc: out_valid=%b in_ready=%b want 0 0", out_valid7, in_ready7);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid7 !== 1'b0 || in_ready7 !== 1'b1 || GCD7 !== 7'd0) begin
      errors++;
      $display("FAIL midrst_async: out_valid=%b in_ready=%b gcd=%0d want 0 1 0", out_valid7, in_ready7, GCD7);
    end
`ifdef GCD_CYCLE_CNT_EN
    checks++;
    if (CYCLES7 !== 8'd0) begin
      errors++;
      $display("FAIL midrst_cycles: got %0d want 0", CYCLES7);
    end
`endif
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_pulse: out_valid=%b want 0", out_valid7);
    end
    rst_n = 1'b1;
    do7(7'd79, 7'd64, g, cyc, cp, to, pv, pr);
    checks++;
    if (to || g !== 7'd1) begin
      errors++;
      $display("FAIL midrst_next: got %0d (timeout=%0d) want 1", g, to);
    end
  endtask

  task automatic test_random;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] g;
    int cyc;
    logic [7:0] cp;
    bit to;
    logic pv;
    logic pr;
    int exp_v;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 7'($urandom_range(0, 127));
      b = 7'($urandom_range(0, 127));
      if ((i % 10) == 0) b = a;
      exp_v = ref_gcd(int'(a), int'(b));
      do7(a, b, g, cyc, cp, to, pv, pr);
      checks++;
      if (to || int'(g) != exp_v) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL rand_gcd(%0d,%0d): got %0d want %0d", a, b, g, exp_v);
      end
      checks++;
      if (cyc < 1 || cyc > 15 || int'(cp) != cyc) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL rand_cycles(%0d,%0d): latency=%0d cycles_port=%0d want equal in 1..15", a, b, cyc, cp);
      end
      checks++;
      if (pv !== 1'b0 || pr !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL rand_handshake(%0d,%0d): out_valid=%b in_ready=%b want 0 1", a, b, pv, pr);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_wide_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
